// File: rtl/sniffer_pkg.sv
// Shared types and constants for the packet sniffer control path.
package sniffer_pkg;

  // Per-packet sequencing states of the match controller.
  typedef enum logic [2:0] {
    LOAD_COMP_REG   = 3'd0,
    IDLE            = 3'd1,
    LOAD_INPUT_FIFO = 3'd2,
    COMPARE         = 3'd3,
    WAIT            = 3'd4,
    MATCH_FOUND     = 3'd5,
    LOAD_MEMORY     = 3'd6,
    ERROR           = 3'd7
  } state_t;

  // Default comparator channel assignment.
  localparam int unsigned CH_PORT = 0;
  localparam int unsigned CH_IP   = 1;
  localparam int unsigned CH_MAC  = 2;
  localparam int unsigned CH_URL  = 3;

  // Wide enough for a comparator latency of up to 15 cycles.
  localparam int unsigned WAIT_W  = 4;
  // Wide enough to hold a popcount over up to 16 channels.
  localparam int unsigned SCORE_W = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for all sniffer statistics.
// A clear always wins over a same-cycle increment.
module sat_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/packet_match_controller.sv
// Per-packet sequencing FSM for the sniffer datapath: config wait, FIFO admit,
// comparator drain, fixed pipeline wait, match scoring and statistics.
module packet_match_controller
  import sniffer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned HIT_W     = 64,
  parameter int unsigned CMP_LAT   = 4,
  parameter int unsigned MATCH_MIN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      update_done,
  input  logic                      ready,
  input  logic                      valid,
  input  logic                      eop,
  input  logic                      error,
  input  logic                      rdempty,
  input  logic [NUM_CH-1:0]         match,
  input  logic [NUM_CH-1:0]         match_mask,
  input  logic                      hits_clr,
  output logic                      rdreq,
  output logic                      inc_addr,
  output logic                      addr,
  output logic                      clear,
  output logic                      busy,
  output logic [NUM_CH*HIT_W-1:0]   hits,
  output logic [HIT_W-1:0]          pkt_count,
  output logic [HIT_W-1:0]          drop_count
);

  // Number of set bits in a channel vector.
  function automatic logic [SCORE_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [SCORE_W-1:0] n;
    n = {SCORE_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + SCORE_W'(v[i]);
    end
    return n;
  endfunction

  state_t              state_d,    state_q;
  logic [WAIT_W-1:0]   wait_cnt_d, wait_cnt_q;
  logic                rdreq_d,    rdreq_q;
  logic                inc_addr_d, inc_addr_q;
  logic                addr_d,     addr_q;
  logic                clear_d,    clear_q;
  logic                busy_d,     busy_q;

  logic [SCORE_W-1:0]  score_s;
  logic                capture_s;
  logic [NUM_CH-1:0]   hit_inc_s;
  logic                pkt_inc_s;
  logic                drop_inc_s;

  // Only enabled channels count towards the capture decision.
  assign score_s   = popcount(match & match_mask);
  assign capture_s = (score_s >= SCORE_W'(MATCH_MIN));

  // Next-state and wait-counter logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      LOAD_COMP_REG: begin
        if (update_done) begin
          state_d = IDLE;
        end else begin
          state_d = LOAD_COMP_REG;
        end
      end
      IDLE: begin
        if (ready && valid) begin
          state_d = LOAD_INPUT_FIFO;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_INPUT_FIFO: begin
        // An erroring packet that also ends this cycle needs no drain.
        if (error && eop) begin
          state_d = IDLE;
        end else if (error) begin
          state_d = ERROR;
        end else if (eop) begin
          state_d = COMPARE;
        end else begin
          state_d = LOAD_INPUT_FIFO;
        end
      end
      COMPARE: begin
        if (rdempty) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(CMP_LAT - 1);
        end else begin
          state_d = COMPARE;
        end
      end
      WAIT: begin
        // Counts CMP_LAT-1 down to 0, giving exactly CMP_LAT cycles here.
        if (wait_cnt_q == {WAIT_W{1'b0}}) begin
          state_d = MATCH_FOUND;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      MATCH_FOUND: begin
        if (capture_s) begin
          state_d = LOAD_MEMORY;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_MEMORY: begin
        state_d = IDLE;
      end
      ERROR: begin
        if (eop) begin
          state_d = IDLE;
        end else begin
          state_d = ERROR;
        end
      end
      default: begin
        state_d    = LOAD_COMP_REG;
        wait_cnt_d = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Moore outputs decoded from the next state so they line up with the state register.
  always_comb begin
    addr_d     = 1'b0;
    clear_d    = 1'b0;
    rdreq_d    = 1'b0;
    inc_addr_d = 1'b0;
    busy_d     = (state_d != IDLE);
    case (state_d)
      LOAD_COMP_REG:   addr_d     = 1'b1;
      IDLE:            clear_d    = 1'b1;
      LOAD_INPUT_FIFO: rdreq_d    = 1'b1;
      MATCH_FOUND:     clear_d    = 1'b1;
      LOAD_MEMORY:     inc_addr_d = 1'b1;
      default: begin
        addr_d     = 1'b0;
        clear_d    = 1'b0;
        rdreq_d    = 1'b0;
        inc_addr_d = 1'b0;
      end
    endcase
  end

  // State, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_COMP_REG;
      wait_cnt_q <= {WAIT_W{1'b0}};
      addr_q     <= 1'b1;
      busy_q     <= 1'b1;
      clear_q    <= 1'b0;
      rdreq_q    <= 1'b0;
      inc_addr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      clear_q    <= clear_d;
      rdreq_q    <= rdreq_d;
      inc_addr_q <= inc_addr_d;
    end
  end

  assign rdreq    = rdreq_q;
  assign inc_addr = inc_addr_q;
  assign addr     = addr_q;
  assign clear    = clear_q;
  assign busy     = busy_q;

  // Statistics ignore the capture mask: every raw match is counted.
  assign hit_inc_s  = (state_q == MATCH_FOUND) ? match : {NUM_CH{1'b0}};
  assign pkt_inc_s  = (state_q == MATCH_FOUND);
  assign drop_inc_s = (state_q == LOAD_INPUT_FIFO) && error;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hits
    sat_counter #(.W(HIT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (hits_clr),
      .inc   (hit_inc_s[i]),
      .count (hits[i*HIT_W +: HIT_W])
    );
  end

  sat_counter #(.W(HIT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (hits_clr),
    .inc   (pkt_inc_s),
    .count (pkt_count)
  );

  sat_counter #(.W(HIT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (hits_clr),
    .inc   (drop_inc_s),
    .count (drop_count)
  );

endmodule

// File: tb/tb_packet_match_controller.sv
// Directed bench for packet_match_controller: two instances share all inputs,
// one capturing on a single enabled match and one requiring two.
module tb_packet_match_controller;

  localparam int unsigned NCH = 4;
  localparam int unsigned HW  = 8;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, update_done, ready, valid, eop, error, rdempty, hits_clr;
  logic [NCH-1:0] match, match_mask;

  logic              rdreq, inc_addr, addr, clear, busy;
  logic [NCH*HW-1:0] hits;
  logic [HW-1:0]     pkt_count, drop_count;

  logic              rdreq2, inc_addr2, addr2, clear2, busy2;
  logic [NCH*HW-1:0] hits2;
  logic [HW-1:0]     pkt_count2, drop_count2;

  int checks = 0;
  int errors = 0;

  packet_match_controller #(.NUM_CH(NCH), .HIT_W(HW), .CMP_LAT(LAT), .MATCH_MIN(1)) dut (
    .clk(clk), .rst(rst), .update_done(update_done), .ready(ready), .valid(valid),
    .eop(eop), .error(error), .rdempty(rdempty), .match(match), .match_mask(match_mask),
    .hits_clr(hits_clr), .rdreq(rdreq), .inc_addr(inc_addr), .addr(addr), .clear(clear),
    .busy(busy), .hits(hits), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  packet_match_controller #(.NUM_CH(NCH), .HIT_W(HW), .CMP_LAT(LAT), .MATCH_MIN(2)) dut2 (
    .clk(clk), .rst(rst), .update_done(update_done), .ready(ready), .valid(valid),
    .eop(eop), .error(error), .rdempty(rdempty), .match(match), .match_mask(match_mask),
    .hits_clr(hits_clr), .rdreq(rdreq2), .inc_addr(inc_addr2), .addr(addr2), .clear(clear2),
    .busy(busy2), .hits(hits2), .pkt_count(pkt_count2), .drop_count(drop_count2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag, input logic [31:0] h, input logic [7:0] p,
                                input logic [7:0] d);
    chk({tag, "_hits"}, 64'(hits), 64'(h));
    chk({tag, "_pkt"},  64'(pkt_count), 64'(p));
    chk({tag, "_drop"}, 64'(drop_count), 64'(d));
  endtask

  task automatic reset_and_config();
    rst = 1'b1; update_done = 1'b0; ready = 1'b0; valid = 1'b0; eop = 1'b0;
    error = 1'b0; rdempty = 1'b0; hits_clr = 1'b0; match = 4'h0; match_mask = 4'h0;
    step();
    step();
    chk("rst_outs", 64'({addr, busy, clear, rdreq, inc_addr}), 64'(5'b11000));
    chk("rst_addr2", 64'(addr2), 64'(1'b1));
    check_counters("rst", 32'h0, 8'h0, 8'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cfg_wait_addr", 64'({addr, busy, clear}), 64'(3'b110));
    end
    update_done = 1'b1;
    step();
    update_done = 1'b0;
    chk("cfg_idle", 64'({addr, busy, clear}), 64'(3'b001));
    chk("cfg_idle2", 64'({busy2, clear2}), 64'(2'b01));
  endtask

  // One full packet from IDLE back to IDLE, with two COMPARE cycles.
  task automatic packet(input logic [3:0] m, input logic [3:0] mk, input logic cap1,
                        input logic cap2, input logic clr_mf);
    int wc;
    match = m; match_mask = mk; rdempty = 1'b0;
    ready = 1'b1; valid = 1'b1;
    step();
    ready = 1'b0; valid = 1'b0;
    chk("lif_rdreq", 64'({rdreq, rdreq2, busy}), 64'(3'b111));
    step();
    chk("lif_hold", 64'(rdreq), 64'(1'b1));
    eop = 1'b1;
    step();
    eop = 1'b0;
    chk("cmp_outs", 64'({rdreq, clear, inc_addr, busy}), 64'(4'b0001));
    step();
    chk("cmp_hold", 64'({rdreq, clear, inc_addr, busy}), 64'(4'b0001));
    rdempty = 1'b1;
    step();
    wc = 0;
    while (clear !== 1'b1 && wc < 20) begin
      wc++;
      step();
    end
    chk("wait_cycles", 64'(wc), 64'(LAT));
    chk("mf_busy", 64'(busy), 64'(1'b1));
    hits_clr = clr_mf;
    step();
    hits_clr = 1'b0;
    chk("inc_addr", 64'(inc_addr), 64'(cap1));
    chk("inc_addr2", 64'(inc_addr2), 64'(cap2));
    step();
    chk("end_idle", 64'({busy, clear, inc_addr}), 64'(3'b010));
    chk("end_idle2", 64'({busy2, clear2, inc_addr2}), 64'(3'b010));
    rdempty = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and configuration load.
    reset_and_config();

    // Two enabled matches: both instances capture.
    packet(4'b0101, 4'hF, 1'b1, 1'b1, 1'b0);
    check_counters("p1", 32'h0001_0001, 8'd1, 8'd0);
    chk("p1_hits2", 64'(hits2), 64'(32'h0001_0001));

    // Match only on a masked-off channel: no capture, still counted.
    packet(4'b0010, 4'b1101, 1'b0, 1'b0, 1'b0);
    check_counters("p2", 32'h0001_0101, 8'd2, 8'd0);

    // Score 2: capture for both thresholds.
    packet(4'b0011, 4'hF, 1'b1, 1'b1, 1'b0);
    check_counters("p3", 32'h0001_0202, 8'd3, 8'd0);

    // Score 1: captured only when one match suffices.
    packet(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0);
    check_counters("p4", 32'h0001_0203, 8'd4, 8'd0);
    chk("p4_pkt2", 64'(pkt_count2), 64'(8'd4));

    // Error mid-packet, eop three cycles later.
    ready = 1'b1; valid = 1'b1;
    step();
    ready = 1'b0; valid = 1'b0;
    step();
    error = 1'b1;
    step();
    error = 1'b0;
    chk("err_state", 64'({rdreq, clear, inc_addr, busy}), 64'(4'b0001));
    chk("err_drop", 64'(drop_count), 64'(8'd1));
    step();
    step();
    chk("err_hold", 64'({clear, busy}), 64'(2'b01));
    eop = 1'b1;
    step();
    eop = 1'b0;
    chk("err_idle", 64'({clear, busy}), 64'(2'b10));
    check_counters("err1", 32'h0001_0203, 8'd4, 8'd1);

    // Error and eop together: straight back to IDLE.
    ready = 1'b1; valid = 1'b1;
    step();
    ready = 1'b0; valid = 1'b0;
    error = 1'b1; eop = 1'b1;
    step();
    error = 1'b0; eop = 1'b0;
    chk("erreop_idle", 64'({clear, busy}), 64'(2'b10));
    check_counters("err2", 32'h0001_0203, 8'd4, 8'd2);
    chk("err2_drop2", 64'(drop_count2), 64'(8'd2));

    // Saturation: 260 packets hitting the url channel.
    for (int i = 0; i < 260; i++) begin
      packet(4'b1000, 4'hF, 1'b1, 1'b0, 1'b0);
    end
    check_counters("sat", 32'hFF01_0203, 8'd255, 8'd2);
    chk("sat_hits2", 64'(hits2), 64'(32'hFF01_0203));
    chk("sat_pkt2", 64'(pkt_count2), 64'(8'd255));

    // Clear on the MATCH_FOUND cycle beats that cycle's increments.
    packet(4'b1000, 4'hF, 1'b1, 1'b0, 1'b1);
    check_counters("clr", 32'h0, 8'd0, 8'd0);

    // Counting resumes after a clear.
    packet(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    check_counters("post_clr", 32'h0001_0000, 8'd1, 8'd0);

    // Reset during WAIT abandons the packet.
    match = 4'b0101; match_mask = 4'hF;
    ready = 1'b1; valid = 1'b1;
    step();
    ready = 1'b0; valid = 1'b0;
    eop = 1'b1;
    step();
    eop = 1'b0;
    rdempty = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rdempty = 1'b0;
    chk("wrst_outs", 64'({addr, busy, clear, inc_addr}), 64'(4'b1100));
    check_counters("wrst", 32'h0, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("wrst_no_inc", 64'({inc_addr, addr}), 64'(2'b01));
    end
    update_done = 1'b1;
    step();
    update_done = 1'b0;
    chk("wrst_idle", 64'({addr, busy, clear}), 64'(3'b001));
    check_counters("wrst_end", 32'h0, 8'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
